instr_encoder: RTL

- Streaming MIPS instruction encoder: the encode-side counterpart of the control-unit opcode/funct decoders.
- Accepts symbolic ops (op code plus register/immediate fields) over a valid/ready handshake.
- Packs each op into a 32-bit machine word and emits it with an auto-incrementing instruction-memory byte address.
- Used by the testbench/loader path to fill instruction memory before the P4 CPU runs, and to cross-check decoder outputs.

---
 rtl/instr_pkg.sv | 40 ++++
 rtl/instr_pack.sv | 35 +++
 rtl/instr_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants: op-select codes, primary opcodes, R-type funct values.
// Same opcode/funct values the control-unit decoders match against.
package instr_pkg;

    typedef enum logic [3:0] {
        OP_ADDU = 4'd0,
        OP_SUBU = 4'd1,
        OP_JR   = 4'd2,
        OP_ORI  = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_BEQ  = 4'd6,
        OP_LUI  = 4'd7,
        OP_NOP  = 4'd8,
        OP_END  = 4'd15
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    // shamt is always zero for the R-type ops this encoder supports
    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational op-to-machine-word mapper; fields an op does not use are forced to zero.
// Zero latency, no state, no backpressure.
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal,
    output logic        is_end
);

    always_comb begin
        word   = '0;
        legal  = 1'b1;
        is_end = 1'b0;
        case (op)
            OP_ADDU: word = r_word(rs, rt, rd, FN_ADDU);
            OP_SUBU: word = r_word(rs, rt, rd, FN_SUBU);
            OP_JR:   word = r_word(rs, 5'd0, 5'd0, FN_JR);
            OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
            OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
            OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
            OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
            OP_LUI:  word = i_word(OPC_LUI, 5'd0, rt, imm);
            OP_NOP:  word = '0;
            OP_END:  is_end = 1'b1;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS encoder: accepts symbolic ops, emits packed words with incrementing byte addresses.
// One-cycle accept-to-output latency; single output register stalls in_ready while out_ready is low.
module instr_encoder
    import instr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [15:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err_op,
    output logic             err_full
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state, state_n;
    logic        end_seen, end_seen_n;
    logic        out_valid_n, err_op_n, err_full_n;
    logic [31:0] pk_word;
    logic        pk_legal, pk_end;
    logic        accept, full, emit, overflow;

    instr_pack u_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm),
        .word   (pk_word),
        .legal  (pk_legal),
        .is_end (pk_end)
    );

    assign in_ready = (state == S_RUN) && !end_seen && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign full     = (count == CNT_W'(DEPTH));
    assign emit     = accept && pk_legal && !pk_end && !full;
    assign overflow = accept && pk_legal && !pk_end && full;
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    // Next-cycle view of the output register lets RUN->DONE fire on the same
    // edge that the last word handshakes.
    always_comb begin
        out_valid_n = emit || (out_valid && !out_ready);
        end_seen_n  = end_seen || (accept && pk_end);
        err_op_n    = err_op || (accept && !pk_legal);
        err_full_n  = err_full || overflow;
        state_n     = state;
        case (state)
            S_IDLE: if (start) state_n = S_RUN;
            S_RUN:  if ((end_seen_n || err_full_n) && !out_valid_n) state_n = S_DONE;
            S_DONE: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (start) state_n = S_RUN;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            end_seen  <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_instr <= '0;
            count     <= '0;
            err_op    <= 1'b0;
            err_full  <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                end_seen  <= 1'b0;
                out_valid <= 1'b0;
                count     <= '0;
                err_op    <= 1'b0;
                err_full  <= 1'b0;
            end else begin
                end_seen  <= end_seen_n;
                out_valid <= out_valid_n;
                err_op    <= err_op_n;
                err_full  <= err_full_n;
                if (emit) begin
                    out_addr  <= BASE_ADDR + (32'(count) << 2);
                    out_instr <= pk_word;
                    count     <= count + 1'b1;
                end
            end
        end
    end

endmodule
